// File: rtl/mul_accumulator.sv
// mul_accumulator: accumulate half of the MAC datapath.
// Takes unsigned products from the combinational multiplier over a
// valid/ready handshake and sums them, with saturation, into a wider
// accumulator. A group closes on in_last or on the K-th beat. The result
// is then held on an output valid/ready handshake until downstream takes it.
//
// Handshake semantics (both ports): a transfer happens on a rising edge
// where valid && ready are both 1. A producer that raises valid keeps its
// data stable until the transfer. ready never depends on the same port's
// valid. in_ready is the only combinational output and is a function of
// state and clr alone.
module mul_accumulator #(
  parameter int N     = 4,
  parameter int K     = 8,
  // Must be at least 2N. With the defaults, 12 bits hold K full-scale
  // products with one bit of headroom.
  parameter int ACC_W = 12,
  localparam int CW   = $clog2(K + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2*N-1:0]   p,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc,
  output logic [CW-1:0]    count,
  output logic             ovf,
  // Debug view of the FSM: 0 = ACCUM, 1 = HOLD.
  output logic             state_dbg
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Count value on which the next accepted beat becomes the K-th one.
  localparam logic [CW-1:0]    K_LAST  = CW'(K - 1);
  localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

  state_t           state;
  logic             accept;
  logic [ACC_W:0]   sum_wide;
  logic             sat_hit;
  logic [ACC_W-1:0] acc_next;
  logic             close_grp;

  // Ready to accept only while accumulating. clr blocks acceptance in the
  // same cycle, so a beat offered alongside clr stays with the producer.
  assign in_ready  = (state == ACCUM) && !clr;
  assign accept    = in_valid && in_ready;
  assign state_dbg = (state == HOLD);

  // Saturating add: sum at ACC_W+1 bits with p zero-extended. The carry
  // bit means the true sum no longer fits, so clamp to all-ones.
  always_comb begin
    sum_wide  = {1'b0, acc} + {{(ACC_W + 1 - 2*N){1'b0}}, p};
    sat_hit   = sum_wide[ACC_W];
    acc_next  = sat_hit ? ACC_MAX : sum_wide[ACC_W-1:0];
    // The K-th beat closes the group whether or not in_last is set, so
    // count can never pass K.
    close_grp = in_last || (count == K_LAST);
  end

  // FSM and registered outputs. clr beats accept and release. Release
  // clears the group, so the next beat is taken one cycle later (the
  // bubble between groups).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (accept) begin
            acc   <= acc_next;
            count <= count + CW'(1);
            ovf   <= ovf | sat_hit;
            if (close_grp) begin
              state     <= HOLD;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          // acc, count and ovf stay frozen until downstream takes the result.
          if (out_ready) begin
            state     <= ACCUM;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ACCUM;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_accumulator.sv
// Directed testbench for mul_accumulator. Two instances share one stimulus:
// dut uses the default ACC_W=12, and dut_b uses ACC_W=10 to reach
// saturation. Both see identical handshakes, so they move in lockstep.
module tb_mul_accumulator;

  localparam int N  = 4;
  localparam int K  = 8;
  localparam int CW = $clog2(K + 1);

  logic clk = 1'b0;
  logic rst;
  logic clr;
  logic in_valid;
  logic [2*N-1:0] p;
  logic in_last;
  logic out_ready;

  logic          in_ready, out_valid, ovf, state_dbg;
  logic [11:0]   acc;
  logic [CW-1:0] count;

  logic          in_ready_b, out_valid_b, ovf_b, state_dbg_b;
  logic [9:0]    acc_b;
  logic [CW-1:0] count_b;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  mul_accumulator #(.N(N), .K(K), .ACC_W(12)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .p(p), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .acc(acc), .count(count), .ovf(ovf), .state_dbg(state_dbg)
  );

  mul_accumulator #(.N(N), .K(K), .ACC_W(10)) dut_b (
    .clk(clk), .rst(rst), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready_b), .p(p), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .acc(acc_b), .count(count_b), .ovf(ovf_b), .state_dbg(state_dbg_b)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge, one ns later comb outputs are settled.
  task automatic drive(input logic v, input logic [2*N-1:0] pv, input logic l,
                       input logic ordy, input logic c);
    in_valid  = v;
    p         = pv;
    in_last   = l;
    out_ready = ordy;
    clr       = c;
    #1;
  endtask

  // Advance through one rising edge and stop on the next falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_clear();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("rst_acc",   32'(acc), 0);
    check("rst_count", 32'(count), 0);
    check("rst_ovf",   32'(ovf), 0);
    check("rst_oval",  32'(out_valid), 0);
    rst = 1'b0;
    #1;
    check("rst_inrdy", 32'(in_ready), 1);

    // T1: 3 + 5 + 7, last on 7, out_ready held high.
    drive(1'b1, 8'd3, 1'b0, 1'b1, 1'b0); tick();
    check("t1_acc1", 32'(acc), 3);
    check("t1_oval_open", 32'(out_valid), 0);
    drive(1'b1, 8'd5, 1'b0, 1'b1, 1'b0); tick();
    check("t1_acc2", 32'(acc), 8);
    drive(1'b1, 8'd7, 1'b1, 1'b1, 1'b0); tick();
    check("t1_oval",  32'(out_valid), 1);
    check("t1_acc",   32'(acc), 15);
    check("t1_count", 32'(count), 3);
    check("t1_ovf",   32'(ovf), 0);
    check("t1_inrdy_hold", 32'(in_ready), 0);
    drive(1'b1, 8'd2, 1'b0, 1'b1, 1'b0); tick();
    check("t1_rel_oval",  32'(out_valid), 0);
    check("t1_rel_acc",   32'(acc), 0);
    check("t1_rel_count", 32'(count), 0);
    check("t1_rel_inrdy", 32'(in_ready), 1);
    tick();
    check("t1_next_acc",   32'(acc), 2);
    check("t1_next_count", 32'(count), 1);
    idle_clear();

    // T2: eight beats of 225, no last -> auto-close at K.
    for (int i = 0; i < K; i++) begin
      drive(1'b1, 8'd225, 1'b0, 1'b0, 1'b0); tick();
      if (i < K - 1) check("t2_open", 32'(out_valid), 0);
    end
    check("t2_oval",  32'(out_valid), 1);
    check("t2_acc",   32'(acc), 1800);
    check("t2_count", 32'(count), 8);
    check("t2_ovf",   32'(ovf), 0);
    check("t2_inrdy", 32'(in_ready), 0);
    check("t2_state", 32'(state_dbg), 1);
    tick();
    check("t2_hold_count", 32'(count), 8);
    check("t2_hold_acc",   32'(acc), 1800);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
    check("t2_rel_acc", 32'(acc), 0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // T3: ACC_W=10 saturation; the 12-bit instance does not saturate.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'd225, 1'b0, 1'b0, 1'b0); tick();
    end
    check("t3_b_acc4", 32'(acc_b), 900);
    check("t3_b_ovf4", 32'(ovf_b), 0);
    drive(1'b1, 8'd225, 1'b1, 1'b0, 1'b0); tick();
    check("t3_b_acc",   32'(acc_b), 1023);
    check("t3_b_ovf",   32'(ovf_b), 1);
    check("t3_b_oval",  32'(out_valid_b), 1);
    check("t3_b_count", 32'(count_b), 5);
    check("t3_a_acc",   32'(acc), 1125);
    check("t3_a_ovf",   32'(ovf), 0);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
    check("t3_b_rel_ovf", 32'(ovf_b), 0);
    drive(1'b1, 8'd1, 1'b1, 1'b0, 1'b0); tick();
    check("t3_b2_acc",  32'(acc_b), 1);
    check("t3_b2_ovf",  32'(ovf_b), 0);
    check("t3_b2_oval", 32'(out_valid_b), 1);
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);

    // T4: backpressure holds the result and stalls the producer.
    drive(1'b1, 8'd3, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd7, 1'b1, 1'b0, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'd9, 1'b0, 1'b0, 1'b0); tick();
      check("t4_oval",  32'(out_valid), 1);
      check("t4_acc",   32'(acc), 15);
      check("t4_count", 32'(count), 3);
      check("t4_inrdy", 32'(in_ready), 0);
    end
    drive(1'b1, 8'd9, 1'b0, 1'b1, 1'b0); tick();
    check("t4_rel_acc",   32'(acc), 0);
    check("t4_rel_count", 32'(count), 0);
    check("t4_rel_oval",  32'(out_valid), 0);
    drive(1'b1, 8'd9, 1'b0, 1'b0, 1'b0); tick();
    check("t4_next_acc",   32'(acc), 9);
    check("t4_next_count", 32'(count), 1);
    idle_clear();

    // T5: clr in ACCUM blocks the concurrent beat; clr in HOLD drops result.
    drive(1'b1, 8'd4, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd6, 1'b0, 1'b0, 1'b0); tick();
    check("t5_acc10", 32'(acc), 10);
    drive(1'b1, 8'd4, 1'b0, 1'b0, 1'b1);
    check("t5_clr_inrdy", 32'(in_ready), 0);
    tick();
    check("t5_clr_acc",   32'(acc), 0);
    check("t5_clr_count", 32'(count), 0);
    drive(1'b1, 8'd3, 1'b1, 1'b0, 1'b0); tick();
    check("t5_hold_oval", 32'(out_valid), 1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t5_hclr_oval",  32'(out_valid), 0);
    check("t5_hclr_acc",   32'(acc), 0);
    check("t5_hclr_state", 32'(state_dbg), 0);
    check("t5_hclr_inrdy", 32'(in_ready), 1);

    // T6: asynchronous reset mid-cycle.
    drive(1'b1, 8'd5, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd7, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 8'd8, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("t6_acc20", 32'(acc), 20);
    rst = 1'b1;
    #1;
    check("t6_arst_acc",   32'(acc), 0);
    check("t6_arst_count", 32'(count), 0);
    check("t6_arst_oval",  32'(out_valid), 0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'd6, 1'b1, 1'b0, 1'b0); tick();
    check("t6_acc",   32'(acc), 6);
    check("t6_count", 32'(count), 1);
    check("t6_oval",  32'(out_valid), 1);
    idle_clear();

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
